// File: rtl/ula_arbitro_pkg.sv
// Shared definitions for the ula round-robin front end: ula opcodes and controller states.
package ula_arbitro_pkg;

  localparam logic [2:0] OP_SOMA  = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_NOT   = 3'b101;
  localparam logic [2:0] OP_IGUAL = 3'b110;
  localparam logic [2:0] OP_DIF   = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/ula_arbitro_rr_arbitro2.sv
// Combinational two-way round-robin pick between two valid lines.
module rr_arbitro2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_i,
  output logic grant0_o,
  output logic grant1_o
);

  // last_i = 1 means requester 1 was served most recently, so requester 0 has priority.
  assign grant0_o = valid0_i & (~valid1_i | last_i);
  assign grant1_o = valid1_i & (~valid0_i | ~last_i);

endmodule

// File: rtl/ula_arbitro.sv
// Shares one registered ula between two requesters: round-robin accept, hold operands
// for the ula latency, then return result and flag with a one-cycle done pulse.
module ula_arbitro
  import ula_arbitro_pkg::*;
#(
  parameter int W   = 8,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_op,
  output logic         req0_ack,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         req1_ack,
  output logic [W-1:0] ula_a,
  output logic [W-1:0] ula_b,
  output logic [2:0]   ula_opcode,
  input  logic [W-1:0] ula_s,
  input  logic         ula_flag,
  output logic [W-1:0] res_data,
  output logic         res_flag,
  output logic         done0,
  output logic         done1,
  output logic         busy,
  output state_e       dbg_state
);

  localparam int CW = $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_FLAG = CW'(LAT - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(LAT);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic          flag_q, flag_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  res_q, res_d;
  logic          res_flag_q, res_flag_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          busy_q, busy_d;
  logic          grant0, grant1;
  logic          ack0, ack1;

  rr_arbitro2 u_rr (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .last_i   (last_q),
    .grant0_o (grant0),
    .grant1_o (grant1)
  );

  // Handshake: a request transfers on the rising edge where reqN_valid and reqN_ack are
  // both high; ack is only ever raised in IDLE and the requester must keep its operands
  // stable while valid is high and ack is low. Dropping valid before ack withdraws it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    owner_d    = owner_q;
    flag_d     = flag_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_d      = res_q;
    res_flag_d = res_flag_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    busy_d     = busy_q;
    ack0       = 1'b0;
    ack1       = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          ack0    = grant0;
          ack1    = grant1;
          a_d     = grant1 ? req1_a  : req0_a;
          b_d     = grant1 ? req1_b  : req0_b;
          op_d    = grant1 ? req1_op : req0_op;
          owner_d = grant1;
          last_d  = grant1;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + CW'(1);
        // The flag is combinational on the ula input registers, valid one stage before ula_s.
        if (cnt_q == CNT_FLAG) begin
          flag_d = ula_flag;
        end
        if (cnt_q == CNT_DONE) begin
          res_d      = ula_s;
          res_flag_d = flag_q;
          done0_d    = ~owner_q;
          done1_d    = owner_q;
          busy_d     = 1'b0;
          cnt_d      = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      flag_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_q      <= '0;
      res_flag_q <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      flag_q     <= flag_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_q      <= res_d;
      res_flag_q <= res_flag_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      busy_q     <= busy_d;
    end
  end

  assign req0_ack   = ack0;
  assign req1_ack   = ack1;
  assign ula_a      = a_q;
  assign ula_b      = b_q;
  assign ula_opcode = op_q;
  assign res_data   = res_q;
  assign res_flag   = res_flag_q;
  assign done0      = done0_q;
  assign done1      = done1_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ula_arbitro.sv
// Bench for ula_arbitro with a behavioural 8-bit ula (two register stages) on the same clock.
module tb_ula_arbitro;
  import ula_arbitro_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       req0_ack, req1_ack;
  logic [7:0] ula_a, ula_b, ula_s, res_data;
  logic [2:0] ula_opcode;
  logic       ula_flag, res_flag, done0, done1, busy;
  state_e     dbg_state;

  always #5 clk = ~clk;

  ula_arbitro #(.W(8), .LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ack(req1_ack),
    .ula_a(ula_a), .ula_b(ula_b), .ula_opcode(ula_opcode), .ula_s(ula_s), .ula_flag(ula_flag),
    .res_data(res_data), .res_flag(res_flag), .done0(done0), .done1(done1), .busy(busy),
    .dbg_state(dbg_state)
  );

  // Returns {flag, result} straight from the opcode definitions.
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [8:0] r;
    case (op)
      OP_SOMA:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:   r = {(a < b), a - b};
      OP_AND:   r = {1'b0, a & b};
      OP_OR:    r = {1'b0, a | b};
      OP_XOR:   r = {1'b0, a ^ b};
      OP_NOT:   r = {1'b0, ~a};
      OP_IGUAL: r = {1'b0, 7'd0, a == b};
      default:  r = {1'b0, 7'd0, a != b};
    endcase
    return r;
  endfunction

  // ula: input register stage, registered result; flag combinational on input regs + opcode.
  logic [7:0] ua_q, ub_q;
  logic [2:0] uop_q;
  logic [8:0] s_v, flag_v;
  assign s_v      = alu_ref(ua_q, ub_q, uop_q);
  assign flag_v   = alu_ref(ua_q, ub_q, ula_opcode);
  assign ula_flag = flag_v[8];
  always @(posedge clk) begin
    ua_q  <= ula_a;
    ub_q  <= ula_b;
    uop_q <= ula_opcode;
    ula_s <= s_v[7:0];
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  int         m_pend;
  logic       m_last;
  logic [7:0] m_a, m_b, m_res;
  logic [2:0] m_op;
  logic       m_flag;
  logic [9:0] exp_q[$];
  logic       obs_ack0, obs_ack1;
  int         n_done1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_last = 1'b1; m_res = '0; m_flag = 1'b0;
    m_a = '0; m_b = '0; m_op = '0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ula_a"}, 32'(ula_a), 32'(0));
    check({tag, "_ula_b"}, 32'(ula_b), 32'(0));
    check({tag, "_ula_op"}, 32'(ula_opcode), 32'(0));
    check({tag, "_res_data"}, 32'(res_data), 32'(0));
    check({tag, "_res_flag"}, 32'(res_flag), 32'(0));
    check({tag, "_done"}, 32'({done0, done1}), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  // Asserts rst away from any clock edge; expects outputs cleared with no edge in between.
  task automatic async_reset(input string tag);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive, check combinational acks, clock, check registered outputs.
  task automatic cycle(input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] op0,
                       input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] op1);
    logic g0, g1, e_d0, e_d1;
    logic [9:0] e;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    #1;
    g0 = 1'b0; g1 = 1'b0;
    if (m_pend == 0) begin
      if (v0 && v1) begin g0 = m_last; g1 = ~m_last; end
      else begin g0 = v0; g1 = v1; end
    end
    obs_ack0 = req0_ack; obs_ack1 = req1_ack;
    check("ack0", 32'(req0_ack), 32'(g0));
    check("ack1", 32'(req1_ack), 32'(g1));
    @(posedge clk); #1;
    e_d0 = 1'b0; e_d1 = 1'b0;
    if (g0 || g1) begin
      m_a = g1 ? a1 : a0; m_b = g1 ? b1 : b0; m_op = g1 ? op1 : op0;
      m_last = g1; m_pend = 3;
      exp_q.push_back({g1, alu_ref(m_a, m_b, m_op)});
    end else if (m_pend == 1) begin
      m_pend = 0;
      e = exp_q.pop_front();
      e_d0 = ~e[9]; e_d1 = e[9]; m_flag = e[8]; m_res = e[7:0];
    end else if (m_pend > 1) begin
      m_pend--;
    end
    if (done1) n_done1++;
    check("done0", 32'(done0), 32'(e_d0));
    check("done1", 32'(done1), 32'(e_d1));
    check("busy", 32'(busy), 32'(m_pend > 0));
    check("state", 32'(dbg_state), (m_pend > 0) ? 32'(EXEC) : 32'(IDLE));
    check("res_data", 32'(res_data), 32'(m_res));
    check("res_flag", 32'(res_flag), 32'(m_flag));
    if (m_pend > 0) begin
      check("hold_a", 32'(ula_a), 32'(m_a));
      check("hold_b", 32'(ula_b), 32'(m_b));
      check("hold_op", 32'(ula_opcode), 32'(m_op));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 3'd0);
  endtask

  initial begin
    int d1_before;
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    n_done1 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    idle(1);

    // req0 alone: 0xC8 + 0x64 -> 0x2C with carry, done0 three cycles after accept.
    cycle(1'b1, 8'hC8, 8'h64, OP_SOMA, 1'b0, 8'h00, 8'h00, 3'd0);
    idle(3);
    check("t2_res", 32'(res_data), 32'(8'h2C));
    check("t2_flag", 32'(res_flag), 32'(1));

    // Simultaneous requests after reset: req0 first, req1 (held) next.
    async_reset("t3rst");
    cycle(1'b1, 8'h05, 8'h0A, OP_SUB, 1'b1, 8'hF0, 8'h3C, OP_AND);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 8'hF0, 8'h3C, OP_AND);
    check("t3_res0", 32'(res_data), 32'(8'hFB));
    check("t3_flag0", 32'(res_flag), 32'(1));
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 8'hF0, 8'h3C, OP_AND);
    idle(3);
    check("t3_res1", 32'(res_data), 32'(8'h30));
    check("t3_flag1", 32'(res_flag), 32'(0));

    // Reset in the middle of an operation: cleared at once, no done afterwards.
    cycle(1'b1, 8'h7F, 8'h01, OP_SOMA, 1'b0, 8'h00, 8'h00, 3'd0);
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 3'd0);
    async_reset("t1rst");

    // Both held valid: accepts every 4 cycles alternating 0,1,0,1.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'h11, 8'h22, OP_SOMA, 1'b1, 8'h80, 8'h80, OP_SOMA);
      check("t4_ack0", 32'(obs_ack0), 32'((i % 4 == 0) && ((i / 4) % 2 == 0)));
      check("t4_ack1", 32'(obs_ack1), 32'((i % 4 == 0) && ((i / 4) % 2 == 1)));
      check("t4_done", 32'(done0 | done1), 32'(i % 4 == 3));
      check("t4_busy", 32'(busy), 32'(i % 4 != 3));
    end
    idle(4);

    // Operands churn while busy; ula inputs must not move.
    cycle(1'b1, 8'h12, 8'h34, OP_SOMA, 1'b0, 8'h00, 8'h00, 3'd0);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b0, 8'h00, 8'h00, 3'd0);
    cycle(1'b1, 8'h55, 8'h55, OP_IGUAL, 1'b0, 8'h00, 8'h00, 3'd0);
    idle(3);
    check("t5_igual", 32'(res_data), 32'(8'h01));
    cycle(1'b1, 8'h55, 8'h55, OP_DIF, 1'b0, 8'h00, 8'h00, 3'd0);
    idle(3);
    check("t5_dif", 32'(res_data), 32'(8'h00));

    // req1 pulses valid during EXEC only: never acked, never done.
    d1_before = n_done1;
    cycle(1'b1, 8'h0F, 8'hF0, OP_OR, 1'b0, 8'h00, 8'h00, 3'd0);
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 8'hAA, 8'h55, OP_XOR);
    idle(5);
    check("t6_no_done1", 32'(n_done1 - d1_before), 32'(0));

    // Random traffic against the reference model.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ula_arbitro.md
Name: ula_arbitro

Overview:
Round-robin controller that shares one 8-bit ula instance between two requesters.
- Accepts a request (operands + opcode) through a valid/ack handshake.
- Drives the ALU inputs and holds them stable for the ALU's registered latency.
- Samples the carry/borrow flag and the registered result, then returns both to the winning requester with a one-cycle done pulse.
- Sits between requester blocks (sequencer, register file) and the ula; all share clk.

Parameters:
W, 8, datapath width; must match the ula.
LAT, 2, ALU register stages from operand drive to valid ula_s (input registers plus output register).

Ports:
clk  input  1  system clock; also clocks the ula.
rst  input  1  asynchronous, active-high reset.
req0_valid  input  1  requester 0 has an operation pending.
req0_a  input  W  requester 0 operand A.
req0_b  input  W  requester 0 operand B.
req0_op  input  3  requester 0 ula opcode.
req0_ack  output  1  combinational; transfer happens on this clock edge.
req1_valid / req1_a / req1_b / req1_op / req1_ack  same as requester 0.
ula_a  output  W  registered; drives ula a.
ula_b  output  W  registered; drives ula b.
ula_opcode  output  3  registered; drives ula opcode.
ula_s  input  W  ula registered result.
ula_flag  input  1  ula flag; combinational on ula internal registers and ula_opcode.
res_data  output  W  registered result of the last completed operation.
res_flag  output  1  registered flag of the last completed operation.
done0  output  1  one-cycle pulse: res_data/res_flag belong to requester 0.
done1  output  1  one-cycle pulse for requester 1.
busy  output  1  high while an operation is in flight (EXEC).

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, cnt=0, last=1 (requester 0 wins first).
  - ula_a, ula_b, ula_opcode, res_data, res_flag, done0, done1, busy all 0.
  - An in-flight operation is discarded; no done pulse is issued for it.
- States: IDLE, EXEC.
- Arbitration in IDLE:
  - If exactly one reqN_valid is high, that requester wins.
  - If both are high, the requester != last wins.
  - reqN_ack=1 for the winner in the same cycle; ack is always 0 outside IDLE.
- On the accept edge:
  - ula_a/ula_b/ula_opcode <= winner's operands; owner <= winner; last <= winner; cnt <= 0; state <= EXEC; busy <= 1.
- EXEC: cnt increments every cycle. ula_a, ula_b and ula_opcode are held unchanged; requester inputs are ignored.
  - On the edge leaving cnt==LAT-1: flag_q <= ula_flag. The ula internal operand registers are valid and the opcode is stable at that point.
  - On the edge leaving cnt==LAT:
    - res_data <= ula_s; res_flag <= flag_q.
    - done[owner] <= 1.
    - state <= IDLE; busy <= 0.
- done is a single-cycle pulse, cleared on the next edge.
- The IDLE cycle that shows done may already accept the next request.
- Latency: accept edge to done visible = LAT+1 cycles (3). Peak throughput is one operation per LAT+2 cycles (4).
- res_data/res_flag hold their value until the next completion.
- All opcodes 000..111 are legal and passed through unmodified. The flag is meaningful only for 000 (carry) and 001 (borrow); for other opcodes the ula returns 0 and it is forwarded as-is.
- Valid dropped before ack: no operation is performed. A request held valid while the other requester is served is accepted at the next IDLE.

Decomposition:
- Shared package: opcode constants OP_SOMA=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_NOT=101, OP_IGUAL=110, OP_DIF=111; state encoding IDLE/EXEC.
- One sub-module, rr_arbitro2: combinational 2-way round-robin pick (valid0, valid1, last -> grant0, grant1). FSM, counter and registers stay in ula_arbitro.

Test Plan:
- Bench instantiates ula + ula_arbitro on a common clk.
1. rst pulsed asynchronously mid-EXEC -> all outputs 0 immediately, no done pulse; next request is served normally.
2. req0 only: a=0xC8, b=0x64, op=000 -> req0_ack in the accept cycle; done0 3 cycles later; res_data=0x2C, res_flag=1.
3. Both valid in the same cycle after reset: req0 a=0x05, b=0x0A, op=001; req1 a=0xF0, b=0x3C, op=010 -> req0 served first (res_data=0xFB, res_flag=1), then req1 (res_data=0x30, res_flag=0).
4. Both held valid continuously with constant operands -> acks alternate 0,1,0,1; done pulses exactly 4 cycles apart; busy low only in the accept/done cycles.
5. While busy, req0 changes its operands and opcode every cycle -> ula_a/ula_b/ula_opcode stable until done. Then a=b=0x55, op=110 -> res_data=0x01; op=111 -> 0x00.
6. req1 raises valid for one cycle while EXEC is serving req0 and drops it before IDLE -> req1_ack never asserted, no done1.
